// File: rtl/mem_arbiter.sv
// Memory-side arbiter: grants the icache or the dcache to a single-ported RAM.
// Dcache has priority, with a starvation guard for icache and a per-grant timeout.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        timeout,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_IGNT, S_DGNT} state_t;
    typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ramstate_t;

    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] LP_TIMER_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    ramstate_t  w_ram;
    logic [3:0] r_starve;
    logic [3:0] w_starve_next;
    logic [7:0] r_timer;
    logic [7:0] r_err_cnt;
    logic       r_timeout;
    logic       w_dreq;
    logic       w_owner_req;
    logic       w_access;
    logic       w_error;
    logic       w_expire;

    assign w_ram   = ramstate_t'(ramstate);
    assign w_dreq  = dREN | dWEN;
    assign timeout = r_timeout;
    assign err_cnt = r_err_cnt;

    // Arbitration, grant completion and starvation bookkeeping.
    always_comb begin
        w_next        = r_state;
        w_starve_next = r_starve;
        w_owner_req   = 1'b0;
        w_access      = 1'b0;
        w_error       = 1'b0;
        w_expire      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_dreq && !(iREN && (r_starve == LP_STARVE_MAX))) begin
                    w_next = S_DGNT;
                end else if (iREN) begin
                    w_next = S_IGNT;
                end
            end
            S_IGNT:  w_owner_req = iREN;
            S_DGNT:  w_owner_req = w_dreq;
            default: w_next = S_IDLE;
        endcase

        if (r_state != S_IDLE) begin
            w_access = w_owner_req && (w_ram == RAM_ACCESS);
            w_error  = w_owner_req && (w_ram == RAM_ERROR);
            // The last allowed waiting cycle: expire registers the pulse for the IDLE cycle.
            w_expire = w_owner_req && !w_access && (r_timer == LP_TIMER_LAST);

            if (!w_owner_req || w_access || w_expire) begin
                w_next = S_IDLE;
            end

            if (w_access) begin
                if ((r_state == S_DGNT) && iREN) begin
                    w_starve_next = (r_starve == LP_STARVE_MAX) ? r_starve : r_starve + 4'd1;
                end else begin
                    w_starve_next = '0;
                end
            end
        end
    end

    // RAM strobes and cache returns; strobes follow the owner's live enable.
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;

        case (r_state)
            S_IGNT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (w_access) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            S_DGNT: begin
                ramaddr = daddr;
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore;
                end else begin
                    ramREN = dREN;
                end
                if (w_access) begin
                    dwait = 1'b0;
                    if (!dWEN) begin
                        dload = ramload;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_starve  <= '0;
            r_timer   <= '0;
            r_err_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_starve  <= w_starve_next;
            r_timeout <= w_expire;
            if ((r_state == S_IDLE) || (w_next == S_IDLE)) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 8'd1;
            end
            if (w_error && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned TIMEOUT      = 64;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, timeout;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) u_dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .timeout(timeout), .err_cnt(err_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
        ramstate = RS_FREE;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        idle_inputs();
        iREN = 1'b1; dREN = 1'b1;
        #2;
        n_checks++;
        if ({iwait, dwait, ramREN, ramWEN, timeout, err_cnt} !== {5'b11000, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected %b", {iwait, dwait, ramREN, ramWEN, timeout, err_cnt}, {5'b11000, 8'd0});
        end
        n_checks++;
        if ({ramaddr, ramstore, iload, dload} !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", {ramaddr, ramstore, iload, dload});
        end
        tick(); tick();
        n_checks++;
        if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
            n_fail++;
            $display("FAIL reset_held: got %b expected 0011", {ramREN, ramWEN, iwait, dwait});
        end
        idle_inputs();
        @(negedge CLK) RST = 1'b0;
        tick();
        n_checks++;
        if ({ramREN, ramWEN, iwait, dwait, timeout} !== 5'b00110) begin
            n_fail++;
            $display("FAIL reset_release: got %b expected 00110", {ramREN, ramWEN, iwait, dwait, timeout});
        end
    endtask

    task automatic test_icache_read;
        idle_inputs();
        iREN = 1'b1; iaddr = 32'h40; ramstate = RS_BUSY;
        #1;
        n_checks++;
        if ({ramREN, iwait} !== 2'b01) begin
            n_fail++;
            $display("FAIL iread_arb_latency: got %b expected 01", {ramREN, iwait});
        end
        tick();
        #1;
        n_checks++;
        if ({ramREN, iwait, ramaddr} !== {2'b11, 32'h40}) begin
            n_fail++;
            $display("FAIL iread_grant1: got %h expected %h", {ramREN, iwait, ramaddr}, {2'b11, 32'h40});
        end
        tick();
        ramstate = RS_ACCESS; ramload = 32'h8C010004;
        #1;
        n_checks++;
        if ({ramREN, iwait, iload} !== {2'b10, 32'h8C010004}) begin
            n_fail++;
            $display("FAIL iread_access: got %h expected %h", {ramREN, iwait, iload}, {2'b10, 32'h8C010004});
        end
        tick();
        iREN = 1'b0; ramstate = RS_FREE;
        #1;
        n_checks++;
        if ({ramREN, iwait, iload} !== {2'b01, 32'h0}) begin
            n_fail++;
            $display("FAIL iread_idle: got %h expected %h", {ramREN, iwait, iload}, {2'b01, 32'h0});
        end
        tick();
    endtask

    task automatic test_starvation;
        string seq = "";
        int    both = 0;
        int    done = 0;
        idle_inputs();
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h1000; daddr = 32'h2000;
        ramstate = RS_ACCESS; ramload = 32'h0BAD_F00D;
        for (int c = 0; c < 80 && done < 10; c++) begin
            #1;
            if (!iwait && !dwait) both++;
            if (!iwait) begin seq = {seq, "I"}; done++; end
            if (!dwait) begin seq = {seq, "D"}; done++; end
            tick();
        end
        n_checks++;
        if (seq != "DDDDIDDDDI") begin
            n_fail++;
            $display("FAIL starve_order: got %s expected DDDDIDDDDI", seq);
        end
        n_checks++;
        if (both !== 0) begin
            n_fail++;
            $display("FAIL starve_exclusive: got %0d dual grants expected 0", both);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_dcache_write;
        idle_inputs();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = RS_BUSY;
        tick();
        #1;
        n_checks++;
        if ({ramWEN, ramREN, dwait, ramaddr, ramstore} !== {3'b101, 32'h100, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL dwrite_grant: got %h expected %h", {ramWEN, ramREN, dwait, ramaddr, ramstore}, {3'b101, 32'h100, 32'hDEADBEEF});
        end
        tick();
        ramstate = RS_ACCESS;
        #1;
        n_checks++;
        if ({ramWEN, ramREN, dwait, iwait} !== 4'b1001) begin
            n_fail++;
            $display("FAIL dwrite_access: got %b expected 1001", {ramWEN, ramREN, dwait, iwait});
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if ({ramWEN, ramREN, dwait} !== 3'b001) begin
            n_fail++;
            $display("FAIL dwrite_idle: got %b expected 001", {ramWEN, ramREN, dwait});
        end
        tick();
    endtask

    task automatic test_error_retry;
        int bad = 0;
        idle_inputs();
        iREN = 1'b1; iaddr = 32'h80; ramstate = RS_BUSY;
        tick();
        for (int k = 0; k < 3; k++) begin
            ramstate = RS_ERROR;
            #1;
            if ({iwait, ramREN} !== 2'b11) bad++;
            tick();
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL error_hold: got %0d bad cycles expected 0", bad);
        end
        ramstate = RS_ACCESS; ramload = 32'h12345678;
        #1;
        n_checks++;
        if ({iwait, iload, err_cnt} !== {1'b0, 32'h12345678, 8'd3}) begin
            n_fail++;
            $display("FAIL error_access: got %h expected %h", {iwait, iload, err_cnt}, {1'b0, 32'h12345678, 8'd3});
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if ({iwait, err_cnt} !== {1'b1, 8'd3}) begin
            n_fail++;
            $display("FAIL error_after: got %h expected %h", {iwait, err_cnt}, {1'b1, 8'd3});
        end
        tick();
    endtask

    task automatic test_timeout;
        int bad = 0;
        idle_inputs();
        iREN = 1'b1; iaddr = 32'h200; ramstate = RS_BUSY;
        tick();
        for (int k = 0; k < int'(TIMEOUT); k++) begin
            #1;
            if ({ramREN, iwait, timeout} !== 3'b110) bad++;
            tick();
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL timeout_wait: got %0d bad cycles expected 0", bad);
        end
        #1;
        n_checks++;
        if ({timeout, ramREN, iwait} !== 3'b101) begin
            n_fail++;
            $display("FAIL timeout_pulse: got %b expected 101", {timeout, ramREN, iwait});
        end
        tick();
        n_checks++;
        if ({timeout, ramREN, iwait} !== 3'b011) begin
            n_fail++;
            $display("FAIL timeout_regrant: got %b expected 011", {timeout, ramREN, iwait});
        end
        tick();
        iREN = 1'b0;
        #1;
        n_checks++;
        if ({ramREN, iwait, timeout} !== 3'b010) begin
            n_fail++;
            $display("FAIL drop_strobe: got %b expected 010", {ramREN, iwait, timeout});
        end
        tick();
        n_checks++;
        if ({ramREN, timeout, err_cnt} !== {2'b00, 8'd3}) begin
            n_fail++;
            $display("FAIL drop_idle: got %h expected %h", {ramREN, timeout, err_cnt}, {2'b00, 8'd3});
        end
    endtask

    task automatic test_async_reset;
        idle_inputs();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h300; dstore = 32'hCAFEF00D; ramstate = RS_BUSY;
        tick();
        #1;
        n_checks++;
        if (ramWEN !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: got %b expected 1", ramWEN);
        end
        #2 RST = 1'b1;
        #1;
        n_checks++;
        if ({ramWEN, ramREN, iwait, dwait, timeout, err_cnt, ramaddr, ramstore} !== {5'b00110, 8'd0, 64'd0}) begin
            n_fail++;
            $display("FAIL areset_async: got %h expected %h", {ramWEN, ramREN, iwait, dwait, timeout, err_cnt, ramaddr, ramstore}, {5'b00110, 8'd0, 64'd0});
        end
        #1 RST = 1'b0;
        #1;
        n_checks++;
        if ({ramWEN, dwait} !== 2'b01) begin
            n_fail++;
            $display("FAIL areset_release: got %b expected 01", {ramWEN, dwait});
        end
        tick();
        n_checks++;
        if (ramWEN !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_regrant: got %b expected 1", ramWEN);
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_random;
        int   m_own = 0;
        int   m_starve = 0;
        int   m_timer = 0;
        int   m_err = 0;
        bit   m_tout = 1'b0;
        bit   nxt_tout;
        bit   dreq, oreq, done;
        int   busy_run = 0;
        int   r;
        logic [140:0] exp_v, got_v;
        RST = 1'b1;
        idle_inputs();
        tick();
        @(negedge CLK) RST = 1'b0;
        tick();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (busy_run > 0) begin
                ramstate = RS_BUSY;
                busy_run--;
            end else begin
                r = int'($urandom_range(0, 99));
                if (r == 0) busy_run = 70;
                ramstate = (r < 35) ? RS_ACCESS : (r < 65) ? RS_BUSY : (r < 80) ? RS_FREE : RS_ERROR;
            end
            if ($urandom_range(0, 5) == 0) iREN = ~iREN;
            if ($urandom_range(0, 5) == 0) begin
                dREN = 1'($urandom_range(0, 1));
                dWEN = 1'($urandom_range(0, 1));
            end
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            #1;
            dreq = dREN | dWEN;
            oreq = (m_own == 1) ? iREN : (m_own == 2) ? dreq : 1'b0;
            done = oreq && (ramstate == RS_ACCESS);
            exp_v = {
                !(done && m_own == 1),
                !(done && m_own == 2),
                oreq && (m_own == 1 || !dWEN),
                oreq && (m_own == 2) && dWEN,
                m_tout,
                8'(m_err),
                (m_own == 1) ? iaddr : (m_own == 2) ? daddr : 32'h0,
                (m_own == 2 && dWEN) ? dstore : 32'h0,
                (done && m_own == 1) ? ramload : 32'h0,
                (done && m_own == 2 && !dWEN) ? ramload : 32'h0
            };
            got_v = {iwait, dwait, ramREN, ramWEN, timeout, err_cnt, ramaddr, ramstore, iload, dload};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL random_cycle %0d: got %h expected %h", cyc, got_v, exp_v);
            end
            nxt_tout = 1'b0;
            if (m_own == 0) begin
                m_timer = 0;
                if (dreq && !(iREN && m_starve == int'(STARVE_LIMIT))) m_own = 2;
                else if (iREN) m_own = 1;
            end else if (!oreq) begin
                m_own = 0;
            end else if (done) begin
                if (m_own == 2 && iREN) m_starve = (m_starve < int'(STARVE_LIMIT)) ? m_starve + 1 : m_starve;
                else m_starve = 0;
                m_own = 0;
            end else begin
                if (ramstate == RS_ERROR && m_err < 255) m_err++;
                m_timer++;
                if (m_timer == int'(TIMEOUT)) begin
                    m_own = 0;
                    nxt_tout = 1'b1;
                end
            end
            m_tout = nxt_tout;
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_icache_read();
        test_starvation();
        test_dcache_write();
        test_error_retry();
        test_timeout();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Memory-side arbiter directly downstream of the instruction cache and data cache.
- Consumes the icache miss request (iREN/iaddr) and the dcache read/write request, grants one requester at a time to the single-ported RAM, and returns wait/load.
- Registered grant FSM with RAM-latency handshake, dcache-priority policy with an icache starvation guard, and transaction timeout reporting.

Parameters:
- STARVE_LIMIT, 4, consecutive dcache grants allowed while iREN is pending before icache is forced next (1..15).
- TIMEOUT, 64, cycles a granted transfer may wait for ACCESS before abort (2..255).

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  high = icache must hold; low for exactly the data-valid cycle.
- iload  out  32  instruction word, valid when iREN & ~iwait.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  dcache hold, same rules as iwait.
- dload  out  32  read data, valid when dREN & ~dwait.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- timeout  out  1  one-cycle pulse when a transfer is aborted by TIMEOUT.
- err_cnt  out  8  saturating count of ERROR cycles seen during grants.

Behaviour:
- Reset (RST high, asynchronous): state IDLE, iwait=1, dwait=1, ramREN=ramWEN=0, ramaddr=0, ramstore=0, iload=dload=0, timeout=0, err_cnt=0, starve counter=0, timer=0.
- States: IDLE, IGNT, DGNT.
- IDLE: all RAM strobes low, both waits high. On a cycle with a request:
  - dcache wins (go DGNT), unless iREN is high and starve==STARVE_LIMIT, in which case go IGNT.
  - iREN alone: go IGNT.
  - The grant is registered, so the RAM strobe starts the cycle after the request (1-cycle arbitration latency).
- IGNT:
  - ramREN=1, ramaddr=iaddr (live; caches hold requests stable).
  - iwait=0 and iload=ramload combinationally in the cycle ramstate==ACCESS; next state IDLE.
- DGNT:
  - If dWEN: ramWEN=1, ramstore=dstore. Else ramREN=1.
  - ramaddr=daddr.
  - dWEN and dREN both high: treated as write.
  - On ACCESS: dwait=0, dload=ramload for reads; next state IDLE.
- Non-granted requester: wait held high throughout.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each completed DGNT while iREN was high at completion.
  - Clears on any IGNT completion, or when iREN is low at a DGNT completion.
- Request dropped mid-grant (owner enable low): strobes low that cycle, return to IDLE, no wait pulse, no counter change.
- ramstate ERROR during a grant: wait stays high, strobes held (retry), err_cnt += 1 saturating at 255.
- ramstate FREE or BUSY: hold state.
- Timer: clears on grant entry, increments each grant cycle without ACCESS. On reaching TIMEOUT:
  - Drop strobes.
  - Pulse timeout for 1 cycle.
  - Go IDLE; the requester re-arbitrates.
- At least one IDLE cycle separates back-to-back transfers, so the minimum access is 2 cycles for an immediate ACCESS.
- RST asserted mid-transfer: strobes drop immediately (asynchronous); the transfer is lost, with no completion pulse.

Test Plan:
- iREN=1, iaddr=0x40; RAM returns ACCESS on the 2nd grant cycle with ramload=0x8C010004 -> ramREN high for 2 cycles, iwait low exactly 1 cycle with iload=0x8C010004, then IDLE.
- iREN and dREN asserted together, dcache re-requesting continuously, STARVE_LIMIT=4 -> 4 dcache grants complete, then the 5th grant goes to icache; starve counter returns to 0.
- dREN=dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait low 1 cycle on ACCESS.
- ramstate=ERROR for 3 cycles, then ACCESS -> err_cnt=3, wait stays high until the ACCESS cycle, data delivered correctly.
- ramstate held BUSY, TIMEOUT=64 -> timeout pulses 1 cycle after 64 grant cycles, strobes low, iwait still high, new grant follows.
- RST asserted mid-DGNT -> ramWEN falls without a clock edge, all outputs at reset values, state IDLE after release.
